// File: rtl/secded_pkg.sv
// Shared types and elaboration-time helpers for the Hamming SECDED decoder family.
// Position arithmetic follows the classic layout: parity at powers of two, overall parity at bit 0.
package secded_pkg;

   typedef enum logic [1:0] {
      ST_CLEAN  = 2'b00,
      ST_SINGLE = 2'b01,
      ST_DOUBLE = 2'b10,
      ST_UNCORR = 2'b11
   } secded_status_t;

   // Smallest p with 2**p >= dw + p + 1.
   function automatic int par_bits(input int dw);
      int p;
      p = 1;
      while ((2 ** p) < (dw + p + 1)) p = p + 1;
      return p;
   endfunction

   function automatic logic is_pow2(input int pos);
      return (pos > 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Message bit index held at a non-power-of-two position (d1 at position 3 maps to bit 0).
   function automatic int data_idx(input int pos);
      return pos - $clog2(pos + 1) - 1;
   endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of one codeword.
// Kept standalone so an encoder self-check can reuse it.
module secded_syndrome #(
   parameter  int CODE_W = 16,
   localparam int PAR_W  = $clog2(CODE_W)
) (
   input  logic [CODE_W-1:0] i_code,
   output logic [PAR_W-1:0]  o_syndrome,
   output logic              o_parity
);

   // NOTE: blocking '=' inside always_comb, and a default before the loop so no latch is inferred.
   always_comb begin
      o_syndrome = '0;
      for (int i = 1; i < CODE_W; i++) begin
         if (i_code[i]) o_syndrome = o_syndrome ^ PAR_W'(i);
      end
   end

   assign o_parity = ^i_code;

endmodule

// File: rtl/secded_stream_decoder.sv
// Streaming SECDED decoder: S1 registers the codeword, S2 classifies/corrects into output registers.
// Saturating per-class error counters advance on the output handshake.
module secded_stream_decoder
   import secded_pkg::*;
#(
   parameter  int DATA_W = 11,
   parameter  int CNT_W  = 16,
   localparam int PAR_W  = par_bits(DATA_W),
   localparam int CODE_W = DATA_W + PAR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              detect_only,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_status,
   input  logic              cnt_clear,
   output logic [CNT_W-1:0]  cnt_single,
   output logic [CNT_W-1:0]  cnt_double
);

   logic              r_s1_valid;
   logic [CODE_W-1:0] r_s1_code;
   logic              r_s1_detect;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   secded_status_t    r_out_status;

   logic [CNT_W-1:0]  r_cnt_single;
   logic [CNT_W-1:0]  r_cnt_double;

   logic              w_s1_adv;
   logic              w_out_hs;
   logic [PAR_W-1:0]  w_syn;
   logic              w_parity;
   logic              w_syn_in_range;
   logic              w_flip;
   secded_status_t    w_status;
   logic [DATA_W-1:0] w_data;

   assign w_s1_adv = !r_out_valid || out_ready;
   assign in_ready = !r_s1_valid || w_s1_adv;
   assign w_out_hs = r_out_valid && out_ready;

   secded_syndrome #(.CODE_W(CODE_W)) u_syndrome (
      .i_code     (r_s1_code),
      .o_syndrome (w_syn),
      .o_parity   (w_parity)
   );

   // Syndromes at or beyond CODE_W only exist for shortened codes and point at no real bit.
   assign w_syn_in_range = int'(w_syn) < CODE_W;

   always_comb begin
      w_status = ST_CLEAN;
      w_flip   = 1'b0;
      if (w_parity) begin
         if (w_syn_in_range) begin
            w_status = ST_SINGLE;
            w_flip   = (w_syn != '0) && !r_s1_detect;
         end else begin
            w_status = ST_UNCORR;
         end
      end else if (w_syn != '0) begin
         w_status = ST_DOUBLE;
      end
   end

   for (genvar gp = 1; gp < CODE_W; gp++) begin : g_pos
      if (!is_pow2(gp)) begin : g_data
         assign w_data[data_idx(gp)] = r_s1_code[gp] ^ (w_flip && (int'(w_syn) == gp));
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_valid   <= 1'b0;
         r_s1_code    <= '0;
         r_s1_detect  <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_status <= ST_CLEAN;
      end else begin
         if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1_code   <= in_code;
               r_s1_detect <= detect_only;
            end
         end
         if (w_s1_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_out_data   <= w_data;
               r_out_status <= w_status;
            end
         end
      end
   end

   // Clear wins over a same-cycle handshake; counters stick at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt_single <= '0;
         r_cnt_double <= '0;
      end else if (cnt_clear) begin
         r_cnt_single <= '0;
         r_cnt_double <= '0;
      end else if (w_out_hs) begin
         if ((r_out_status == ST_SINGLE) && (r_cnt_single != '1))
            r_cnt_single <= r_cnt_single + 1'b1;
         if (((r_out_status == ST_DOUBLE) || (r_out_status == ST_UNCORR)) && (r_cnt_double != '1))
            r_cnt_double <= r_cnt_double + 1'b1;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_status = r_out_status;
   assign cnt_single = r_cnt_single;
   assign cnt_double = r_cnt_double;

endmodule
